// File: rtl/dkong3_obj_dma.sv
// dkong3_obj_dma: per-frame sprite attribute copy from CPU work RAM into the
// object RAM DMA write port. Stands in for the discrete 8257 DMA channel.
// A CPU trigger arms the engine; it waits for vblank, requests the CPU bus,
// streams LEN bytes (read, wait RD_LAT ticks, write) and then releases the bus.
module dkong3_obj_dma #(
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter logic [8:0]  DST_BASE = 9'h000,
  parameter int          LEN      = 384,
  parameter int          RD_LAT   = 1
) (
  input  logic        I_CLK_24M,
  input  logic        I_RST,
  input  logic        I_CE,
  input  logic        I_START,
  input  logic        I_BANK,
  input  logic        I_VBLANK,
  input  logic        I_BUSAK,
  input  logic [7:0]  I_SRC_D,
  output logic        O_BUSRQ,
  output logic [15:0] O_SRC_A,
  output logic        O_SRC_RD,
  output logic [9:0]  O_OBJ_DMA_A,
  output logic [7:0]  O_OBJ_DMA_D,
  output logic        O_OBJ_DMA_CE,
  output logic        O_BUSY,
  output logic        O_DONE
);

  // Reject illegal configurations while elaborating.
  if (LEN < 1 || LEN > 512) begin : g_len_check
    $error("dkong3_obj_dma: LEN must be in 1..512");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_check
    $error("dkong3_obj_dma: RD_LAT must be in 1..3");
  end

  localparam logic [8:0] LAST_CNT  = 9'(LEN - 1);
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_RELEASE
  } state_t;

  state_t     r_state;
  logic [8:0] r_cnt;
  logic [1:0] r_wcnt;
  logic [7:0] r_data;
  logic       r_bank;
  logic       r_hold;
  logic       r_start_q;
  logic       r_done;

  state_t     w_state_nxt;
  logic [8:0] w_cnt_nxt;
  logic [1:0] w_wcnt_nxt;
  logic [7:0] w_data_nxt;
  logic       w_bank_nxt;
  logic       w_hold_nxt;
  logic       w_start_q_nxt;
  logic       w_done_nxt;

  logic       w_start_edge;
  logic       w_rd_phase;
  logic       w_wr_phase;
  logic [8:0] w_dst_off;

  assign w_start_edge = I_START & ~r_start_q;
  assign w_rd_phase   = (r_state == S_READ) || (r_state == S_WAIT);
  assign w_wr_phase   = (r_state == S_WRITE);
  assign w_dst_off    = DST_BASE + r_cnt;

  // State and datapath registers; the start detector resets high so a trigger
  // level already present when reset lifts is not mistaken for an edge.
  always_ff @(posedge I_CLK_24M or posedge I_RST) begin
    if (I_RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= 9'd0;
      r_wcnt    <= 2'd0;
      r_data    <= 8'd0;
      r_bank    <= 1'b0;
      r_hold    <= 1'b0;
      r_start_q <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_data    <= w_data_nxt;
      r_bank    <= w_bank_nxt;
      r_hold    <= w_hold_nxt;
      r_start_q <= w_start_q_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state logic; everything advances only on CE ticks. A lost grant
  // parks the engine in its current state, and the regrant tick only clears
  // the hold so the resumed state gets its full tick budget again.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wcnt_nxt    = r_wcnt;
    w_data_nxt    = r_data;
    w_bank_nxt    = r_bank;
    w_hold_nxt    = r_hold;
    w_start_q_nxt = r_start_q;
    w_done_nxt    = 1'b0;
    if (I_CE) begin
      w_start_q_nxt = I_START;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            w_bank_nxt  = I_BANK;
            w_state_nxt = S_ARM;
          end
        end
        S_ARM: begin
          if (I_VBLANK) w_state_nxt = S_REQ;
        end
        S_REQ: begin
          if (I_BUSAK) begin
            w_cnt_nxt   = 9'd0;
            w_wcnt_nxt  = 2'd0;
            w_hold_nxt  = 1'b0;
            w_state_nxt = S_READ;
          end
        end
        S_READ, S_WAIT, S_WRITE: begin
          if (!I_BUSAK) begin
            w_hold_nxt = 1'b1;
            w_wcnt_nxt = 2'd0;
          end else if (r_hold) begin
            w_hold_nxt = 1'b0;
            w_wcnt_nxt = 2'd0;
          end else begin
            case (r_state)
              S_READ: begin
                w_wcnt_nxt  = 2'd0;
                w_state_nxt = S_WAIT;
              end
              S_WAIT: begin
                if (r_wcnt == LAST_WAIT) begin
                  w_data_nxt  = I_SRC_D;
                  w_state_nxt = S_WRITE;
                end else begin
                  w_wcnt_nxt = r_wcnt + 2'd1;
                end
              end
              default: begin
                if (r_cnt == LAST_CNT) begin
                  w_state_nxt = S_RELEASE;
                end else begin
                  w_cnt_nxt   = r_cnt + 9'd1;
                  w_state_nxt = S_READ;
                end
              end
            endcase
          end
        end
        S_RELEASE: begin
          if (!I_BUSAK) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign O_BUSRQ      = (r_state == S_REQ) || w_rd_phase || w_wr_phase;
  assign O_SRC_A      = w_rd_phase ? (SRC_BASE + {7'd0, r_cnt}) : 16'd0;
  assign O_SRC_RD     = w_rd_phase & ~r_hold;
  assign O_OBJ_DMA_A  = w_wr_phase ? {r_bank, w_dst_off} : 10'd0;
  assign O_OBJ_DMA_D  = w_wr_phase ? r_data : 8'd0;
  assign O_OBJ_DMA_CE = w_wr_phase & ~r_hold;
  assign O_BUSY       = (r_state != S_IDLE);
  assign O_DONE       = r_done;

endmodule

// File: tb/tb_dkong3_obj_dma.sv
// Bench for dkong3_obj_dma: directed sequence with a write scoreboard.
// Instance u_dut uses the default configuration; u_wrap uses DST_BASE=9'h1F0,
// LEN=32 to exercise the destination offset wrap.
module tb_dkong3_obj_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        start = 1'b0, bank = 1'b0, vblank = 1'b0, busak = 1'b0;
  logic        start2 = 1'b0, bank2 = 1'b0, vblank2 = 1'b0, busak2 = 1'b0;
  logic [7:0]  src_d, src_d2;
  logic        busrq, src_rd, dma_ce, busy, done;
  logic [15:0] src_a;
  logic [9:0]  dma_a;
  logic [7:0]  dma_d;
  logic        busrq2, src_rd2, dma_ce2, busy2, done2;
  logic [15:0] src_a2;
  logic [9:0]  dma_a2;
  logic [7:0]  dma_d2;

  // Source memory: each byte equals the low byte of its address.
  assign src_d  = src_a[7:0];
  assign src_d2 = src_a2[7:0];

  always #5 clk = ~clk;

  dkong3_obj_dma u_dut (
    .I_CLK_24M(clk), .I_RST(rst), .I_CE(ce), .I_START(start), .I_BANK(bank),
    .I_VBLANK(vblank), .I_BUSAK(busak), .I_SRC_D(src_d), .O_BUSRQ(busrq),
    .O_SRC_A(src_a), .O_SRC_RD(src_rd), .O_OBJ_DMA_A(dma_a), .O_OBJ_DMA_D(dma_d),
    .O_OBJ_DMA_CE(dma_ce), .O_BUSY(busy), .O_DONE(done)
  );

  dkong3_obj_dma #(.DST_BASE(9'h1F0), .LEN(32)) u_wrap (
    .I_CLK_24M(clk), .I_RST(rst), .I_CE(ce), .I_START(start2), .I_BANK(bank2),
    .I_VBLANK(vblank2), .I_BUSAK(busak2), .I_SRC_D(src_d2), .O_BUSRQ(busrq2),
    .O_SRC_A(src_a2), .O_SRC_RD(src_rd2), .O_OBJ_DMA_A(dma_a2), .O_OBJ_DMA_D(dma_d2),
    .O_OBJ_DMA_CE(dma_ce2), .O_BUSY(busy2), .O_DONE(done2)
  );

  int n_chk = 0;
  int n_err = 0;
  int tickn = 0;
  int n_wr = 0, n_done = 0, n_wr2 = 0, n_done2 = 0;
  int t_read = -1, t_rel = -1;
  logic prev_dce = 1'b0, prev_rd = 1'b0, prev_rq = 1'b0, prev_dce2 = 1'b0;
  logic [17:0] q[$];
  logic [17:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor, sampled 1 time unit after each rising clock edge.
  task automatic mon();
    logic [31:0] e;
    if (dma_ce && !prev_dce) begin
      n_wr++;
      e = 32'hFFFF_FFFF;
      if (q.size() > 0) e = {14'd0, q.pop_front()};
      chk("dut_write", {14'd0, dma_a, dma_d}, e);
    end
    if (dma_ce2 && !prev_dce2) begin
      n_wr2++;
      e = 32'hFFFF_FFFF;
      if (q2.size() > 0) e = {14'd0, q2.pop_front()};
      chk("wrap_write", {14'd0, dma_a2, dma_d2}, e);
    end
    if (src_rd && !prev_rd && t_read < 0) t_read = tickn;
    if (!busrq && prev_rq) t_rel = tickn;
    if (done) n_done++;
    if (done2) n_done2++;
    prev_dce  = dma_ce;
    prev_dce2 = dma_ce2;
    prev_rd   = src_rd;
    prev_rq   = busrq;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    mon();
  endtask

  // One CE tick followed by two idle clocks; u_wrap's bus grant follows its request.
  task automatic tick();
    tickn++;
    ce = 1'b1;
    cyc();
    ce = 1'b0;
    cyc();
    cyc();
    busak2 = busrq2;
  endtask

  task automatic xfer(input string tag, input logic b, input int lock_at,
                      input int drop_at, input int rst_at);
    int d0, w0;
    bit lk, dr;
    lk = 0;
    dr = 0;
    q.delete();
    for (int i = 0; i < 384; i++) q.push_back({b, 9'(i), 8'(i)});
    n_wr = 0; t_read = -1; t_rel = -1; d0 = n_done;
    bank = b; start = 1'b1; tick();
    start = 1'b0; bank = ~b; tick();
    chk({tag, "_busy_armed"}, {31'd0, busy}, 1);
    repeat (100) tick();
    chk({tag, "_arm_waits_vblank"}, {31'd0, busrq}, 0);
    vblank = 1'b1; tick();
    vblank = 1'b0;
    chk({tag, "_busrq_in_req"}, {31'd0, busrq}, 1);
    repeat (3) tick();
    busak = 1'b1;
    for (int i = 0; i < 6000 && busrq; i++) begin
      tick();
      if (!lk && n_wr == lock_at + 1 && dma_ce) begin
        start = 1'b1; tick(); start = 1'b0; lk = 1;
      end
      if (!dr && n_wr == drop_at && src_rd && src_a == 16'h6900 + 16'(drop_at)) begin
        tick();
        busak = 1'b0;
        w0 = n_wr;
        repeat (20) tick();
        chk({tag, "_gl_no_writes"}, n_wr, w0);
        chk({tag, "_gl_rd_forced0"}, {31'd0, src_rd}, 0);
        chk({tag, "_gl_ce_forced0"}, {31'd0, dma_ce}, 0);
        chk({tag, "_gl_busrq_held"}, {31'd0, busrq}, 1);
        busak = 1'b1;
        dr = 1;
      end
      if (rst_at >= 0 && n_wr == rst_at) begin
        rst = 1'b1;
        #1;
        chk({tag, "_rst_busrq_async"}, {31'd0, busrq}, 0);
        chk({tag, "_rst_busy"}, {31'd0, busy}, 0);
        chk({tag, "_rst_dma_ce"}, {31'd0, dma_ce}, 0);
        q.delete();
        busak = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) tick();
        chk({tag, "_rst_no_done"}, n_done, d0);
        return;
      end
    end
    chk({tag, "_reached_release"}, {31'd0, busrq}, 0);
    chk({tag, "_write_count"}, n_wr, 384);
    chk({tag, "_sb_empty"}, q.size(), 0);
    if (drop_at < 0) chk({tag, "_ticks_read_to_release"}, t_rel - t_read, 1152);
    tick();
    chk({tag, "_no_done_while_busak"}, n_done, d0);
    busak = 1'b0;
    for (int i = 0; i < 50 && n_done == d0; i++) tick();
    chk({tag, "_done_pulse"}, n_done, d0 + 1);
    chk({tag, "_idle_after_done"}, {31'd0, busy}, 0);
    if (lock_at >= 0) begin
      repeat (20) tick();
      chk({tag, "_single_done"}, n_done, d0 + 1);
      chk({tag, "_no_queued_start"}, {31'd0, busy}, 0);
    end
  endtask

  initial begin
    // Reset with the trigger already high: not a start.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busrq", {31'd0, busrq}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_src_a", {16'd0, src_a}, 0);
    chk("rst_src_rd", {31'd0, src_rd}, 0);
    chk("rst_dma_a_d_ce", {13'd0, dma_a, dma_d, dma_ce}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("held_start_ignored", {31'd0, busy}, 0);
    chk("held_start_no_busrq", {31'd0, busrq}, 0);
    start = 1'b0;
    repeat (2) tick();

    // Nominal bank-1 transfer with a second trigger during the write of byte 10.
    xfer("nom", 1'b1, 10, -1, -1);
    // Grant loss during the wait of byte 50, bank 0.
    xfer("gl", 1'b0, -1, 50, -1);
    // Reset at byte 200, then a normal transfer must still complete.
    xfer("rstmid", 1'b1, -1, -1, 200);
    xfer("after_rst", 1'b1, -1, -1, -1);

    // Destination wrap on the second instance.
    q2.delete();
    for (int i = 0; i < 32; i++) q2.push_back({1'b0, 9'(9'h1F0 + 9'(i)), 8'(i)});
    n_wr2 = 0; n_done2 = 0;
    bank2 = 1'b0; start2 = 1'b1; tick();
    start2 = 1'b0; vblank2 = 1'b1; tick();
    vblank2 = 1'b0;
    for (int i = 0; i < 500 && n_done2 == 0; i++) tick();
    chk("wrap_write_count", n_wr2, 32);
    chk("wrap_sb_empty", q2.size(), 0);
    chk("wrap_done", n_done2, 1);
    chk("wrap_idle", {31'd0, busy2}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dkong3_obj_dma.md
Name: dkong3_obj_dma

Overview:
- Sequencer that copies the sprite attribute table from CPU work RAM into the object RAM's DMA write port (the DMA address, data and enable inputs of the object block) once per frame.
- Replaces the discrete 8257 DMA channel.
- Started by a CPU trigger write. Waits for vertical blank, takes the CPU bus with a request/acknowledge handshake, streams LEN bytes, then releases the bus.
- Sits between the CPU bus mux and the object block.

Parameters:
SRC_BASE, 16'h6900, CPU address of first source byte
DST_BASE, 9'h000, first object RAM offset within the selected bank
LEN, 384, bytes per transfer; legal 1..512
RD_LAT, 1, CE ticks from read strobe to valid I_SRC_D; legal 1..3

Ports:
I_CLK_24M  in  1  system clock
I_RST  in  1  asynchronous reset, active high
I_CE  in  1  pacing strobe, one I_CLK_24M cycle wide; all state advances only on I_CE=1
I_START  in  1  CPU trigger write; level, rising edge detected
I_BANK  in  1  object RAM bank (2PSL) to fill; sampled at start
I_VBLANK  in  1  vertical blank, high during blank
I_BUSAK  in  1  CPU bus grant, high = CPU halted
I_SRC_D  in  8  source read data
O_BUSRQ  out  1  CPU bus request
O_SRC_A  out  16  source address
O_SRC_RD  out  1  source read strobe
O_OBJ_DMA_A  out  10  object RAM write address {bank, offset}
O_OBJ_DMA_D  out  8  object RAM write data
O_OBJ_DMA_CE  out  1  object RAM write enable
O_BUSY  out  1  high from accepted start until release completes
O_DONE  out  1  one I_CLK_24M pulse at completion

Behaviour:
- Reset (async, I_RST=1): state IDLE; all outputs 0; byte counter 0; edge detector primed so that a level already high at reset release is not a start.
- Start detection: I_START rising edge, sampled on I_CE ticks.
  - In IDLE: latch I_BANK, go to ARM.
  - In any other state: ignored; nothing queued.
- ARM: wait for I_VBLANK=1 on a CE tick, then go to REQ.
- REQ: O_BUSRQ=1 (held through RELEASE). Wait for I_BUSAK=1 on a CE tick, then go to READ with count=0.
- READ, one tick:
  - O_SRC_A = SRC_BASE + count, mod 2^16.
  - O_SRC_RD=1.
  - Then go to WAIT.
- WAIT:
  - Address and read strobe held.
  - After RD_LAT ticks, capture I_SRC_D into the data register on the final tick.
  - Then go to WRITE.
- WRITE, one tick:
  - O_OBJ_DMA_A = {bank, (DST_BASE + count) mod 512}.
  - O_OBJ_DMA_D = captured byte.
  - O_OBJ_DMA_CE=1 for the entire WRITE state, from the entering tick to the leaving tick; address and data stable throughout.
  - O_SRC_RD=0.
  - On leaving: if count=LEN-1, go to RELEASE; else count+1 and go to READ.
- Throughput: 2+RD_LAT CE ticks per byte. LEN=384, RD_LAT=1 gives 1152 ticks from the first READ to entry into RELEASE.
- RELEASE: O_BUSRQ=0. Wait for I_BUSAK=0, then go to IDLE and pulse O_DONE for one I_CLK_24M cycle.
- O_BUSY is 1 in ARM, REQ, READ, WAIT, WRITE and RELEASE.
- Grant loss: if I_BUSAK drops during READ, WAIT or WRITE:
  - Freeze at the next CE tick: no state, count or capture advance.
  - O_SRC_RD and O_OBJ_DMA_CE are forced 0; O_BUSRQ stays 1.
  - On regrant, resume the same state with a full tick count, i.e. the WAIT tick count restarts.
- Vblank ending mid-transfer: no effect once REQ has been entered.
- Destination offset wraps within 9 bits and never changes the bank bit.
- Count width: 9 bits. LEN outside 1..512 is a configuration error and must be rejected at elaboration.
- Reset mid-transfer: immediate return to IDLE with O_BUSRQ=0. Object RAM contents are left partial; no O_DONE.
- I_CE=0 continuously: all outputs hold.

Test Plan:
1. Reset then idle: I_RST pulse, I_START held high across reset release -> no start; all outputs 0, O_BUSY=0.
2. Nominal transfer, LEN=384, RD_LAT=1, I_BANK=1, source byte = address[7:0]:
   - start pulse, then VBLANK after 100 ticks, then BUSAK 3 ticks after BUSRQ;
   - required: 384 writes, the first at O_OBJ_DMA_A=10'h200 with data 8'h00 and the last at 10'h37F with data 8'h7F;
   - O_DONE fires after BUSAK falls; total 1152 ticks from the first READ to RELEASE.
3. Busy lockout: second I_START edge during WRITE of byte 10 -> ignored; exactly one transfer, one O_DONE.
4. Grant loss: drop I_BUSAK for 20 ticks during WAIT of byte 50 -> no O_OBJ_DMA_CE pulses while dropped; byte 50 is written once with correct data after regrant; total writes remain 384.
5. Destination wrap: DST_BASE=9'h1F0, LEN=32, bank 0 -> writes 10'h1F0..10'h1FF then 10'h000..10'h00F; bit 9 stays 0.
6. Reset mid-transfer: I_RST asserted at byte 200 -> O_BUSRQ=0 within the same cycle (async); no O_DONE; a new start after reset completes normally.
